// File: rtl/vga_pkg.sv
// Shared VGA constants: IRGB bit positions, black, and default sync polarities.
// Used by the sync generator, pixel generator and output stage.
package vga_pkg;

  localparam int unsigned IRGB_I = 3;
  localparam int unsigned IRGB_R = 2;
  localparam int unsigned IRGB_G = 1;
  localparam int unsigned IRGB_B = 0;

  localparam logic [3:0] COLOR_BLACK = 4'h0;

  localparam logic HSYNC_ACTIVE_DEFAULT = 1'b0;
  localparam logic VSYNC_ACTIVE_DEFAULT = 1'b0;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with synchronous reset to RESET_VAL.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;
    assign dout        = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (reset) begin
          stage_q[i] <= RESET_VAL;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA output stage: fg/bg select with blanking, reverse and frame-counted blink,
// followed by a delay line that keeps colour and sync aligned at the pins.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned PIPE_DEPTH   = 1,
  parameter int unsigned BLINK_LOG2   = 4,
  parameter logic        HSYNC_ACTIVE = HSYNC_ACTIVE_DEFAULT,
  parameter logic        VSYNC_ACTIVE = VSYNC_ACTIVE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] fgColor,
  input  logic [COLOR_W-1:0] bgColor,
  input  logic               pixel,
  input  logic               blink,
  input  logic               reverse,
  input  logic               displayEnable,
  input  logic               hSync,
  input  logic               vSync,
  output logic [COLOR_W-1:0] colorOut,
  output logic               hSyncOut,
  output logic               vSyncOut
);

  localparam int unsigned          BUNDLE_W   = COLOR_W + 2;
  localparam logic [COLOR_W-1:0]   BLACK      = COLOR_W'(COLOR_BLACK);
  localparam logic [BUNDLE_W-1:0]  BUNDLE_RST = {BLACK, ~HSYNC_ACTIVE, ~VSYNC_ACTIVE};

  logic [BLINK_LOG2:0] frame_cnt_q, frame_cnt_d;
  logic                vsync_prev_q, vsync_prev_d;
  logic [COLOR_W-1:0]  color_p1_q, color_p1_d;
  logic                hsync_p1_q, hsync_p1_d;
  logic                vsync_p1_q, vsync_p1_d;

  logic                frame_edge;
  logic                blink_phase;
  logic [COLOR_W-1:0]  eff_fg, eff_bg;
  logic [BUNDLE_W-1:0] bundle_p1, bundle_out;

  // Phase comes from the registered counter, so a pixel sampled on a frame
  // edge still sees the previous phase.
  assign blink_phase = frame_cnt_q[BLINK_LOG2];

  always_comb begin
    frame_edge   = (vsync_prev_q != VSYNC_ACTIVE) && (vSync == VSYNC_ACTIVE);
    frame_cnt_d  = frame_cnt_q + {{BLINK_LOG2{1'b0}}, frame_edge};
    vsync_prev_d = vSync;

    eff_fg = reverse ? bgColor : fgColor;
    eff_bg = reverse ? fgColor : bgColor;

    if (!displayEnable) begin
      color_p1_d = BLACK;
    end else if (pixel && !(blink && blink_phase)) begin
      color_p1_d = eff_fg;
    end else begin
      color_p1_d = eff_bg;
    end

    hsync_p1_d = hSync;
    vsync_p1_d = vSync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      vsync_prev_q <= ~VSYNC_ACTIVE;
      color_p1_q   <= BLACK;
      hsync_p1_q   <= ~HSYNC_ACTIVE;
      vsync_p1_q   <= ~VSYNC_ACTIVE;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      vsync_prev_q <= vsync_prev_d;
      color_p1_q   <= color_p1_d;
      hsync_p1_q   <= hsync_p1_d;
      vsync_p1_q   <= vsync_p1_d;
    end
  end

  // Stages 2..PIPE_DEPTH: pure delay of the aligned bundle.
  assign bundle_p1 = {color_p1_q, hsync_p1_q, vsync_p1_q};

  vga_delay_line #(
    .WIDTH     (BUNDLE_W),
    .DEPTH     (PIPE_DEPTH - 1),
    .RESET_VAL (BUNDLE_RST)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (bundle_p1),
    .dout  (bundle_out)
  );

  assign {colorOut, hSyncOut, vSyncOut} = bundle_out;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out: one instance at PIPE_DEPTH=1/BLINK_LOG2=1,
// one at PIPE_DEPTH=4 with defaults, both fed the same inputs.
module tb_vga_pixel_out;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fg, bg;
  logic       pixel, blink, rev, de, hs, vs;
  logic [3:0] col1, col4;
  logic       hs1, vs1, hs4, vs4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_pixel_out #(.COLOR_W(4), .PIPE_DEPTH(1), .BLINK_LOG2(1)) dut1 (
    .clk(clk), .reset(reset), .fgColor(fg), .bgColor(bg), .pixel(pixel),
    .blink(blink), .reverse(rev), .displayEnable(de), .hSync(hs), .vSync(vs),
    .colorOut(col1), .hSyncOut(hs1), .vSyncOut(vs1)
  );

  vga_pixel_out #(.COLOR_W(4), .PIPE_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .fgColor(fg), .bgColor(bg), .pixel(pixel),
    .blink(blink), .reverse(rev), .displayEnable(de), .hSync(hs), .vSync(vs),
    .colorOut(col4), .hSyncOut(hs4), .vSyncOut(vs4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] blink_tbl [8];
    blink_tbl = '{4'hA, 4'hA, 4'h0, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0};

    // Reset with random inputs for 3 cycles
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fg = 4'($urandom); bg = 4'($urandom);
      {pixel, blink, rev, de, hs, vs} = 6'($urandom);
      tick();
      chk("rst_col1", {4'h0, col1}, 8'h0);
      chk("rst_hs1",  {7'h0, hs1},  8'h1);
      chk("rst_vs1",  {7'h0, vs1},  8'h1);
      chk("rst_col4", {4'h0, col4}, 8'h0);
      chk("rst_hs4",  {7'h0, hs4},  8'h1);
      chk("rst_vs4",  {7'h0, vs4},  8'h1);
    end

    // Select, first cycle after deassert
    reset = 1'b0;
    fg = 4'hC; bg = 4'h1; de = 1'b1; pixel = 1'b1; blink = 1'b0; rev = 1'b0;
    hs = 1'b1; vs = 1'b1;
    tick();
    chk("sel_fg",        {4'h0, col1}, 8'h0C);
    chk("post_rst_col4", {4'h0, col4}, 8'h00);
    pixel = 1'b0;
    tick();
    chk("sel_bg", {4'h0, col1}, 8'h01);
    rev = 1'b1; pixel = 1'b1;
    tick();
    chk("rev_px1", {4'h0, col1}, 8'h01);
    pixel = 1'b0;
    tick();
    chk("rev_px0", {4'h0, col1}, 8'h0C);

    // Blanking priority and 96-cycle hSync pulse
    rev = 1'b0; de = 1'b0; pixel = 1'b1; fg = 4'hF;
    tick();
    chk("blank", {4'h0, col1}, 8'h00);
    for (int i = 0; i < 100; i++) begin
      hs = (i < 96) ? 1'b0 : 1'b1;
      tick();
      chk("hs_pulse1", {7'h0, hs1}, {7'h0, hs});
      chk("hs_pulse4", {7'h0, hs4}, (i >= 3 && i < 99) ? 8'h0 : 8'h1);
      chk("blank_run", {4'h0, col1}, 8'h00);
    end

    // Blink over 8 frames
    de = 1'b1; pixel = 1'b1; blink = 1'b1; fg = 4'hA; bg = 4'h0; hs = 1'b1;
    for (int f = 0; f < 8; f++) begin
      vs = 1'b1;
      tick(); tick();
      chk("blink_frame", {4'h0, col1}, {4'h0, blink_tbl[f]});
      vs = 1'b0;
      tick();
      chk("vs_out1", {7'h0, vs1}, 8'h0);
      tick();
    end

    // Edge coincidence: 1st edge, then sample on the 2nd edge
    vs = 1'b1; tick(); tick();
    vs = 1'b0; tick(); tick();
    vs = 1'b1; tick(); tick();
    vs = 1'b0;
    tick();
    chk("coinc_old_phase", {4'h0, col1}, 8'h0A);
    tick();
    chk("coinc_new_phase", {4'h0, col1}, 8'h00);
    blink = 1'b0;
    tick();
    chk("no_blink", {4'h0, col1}, 8'h0A);

    // PIPE_DEPTH=4 alignment of a single-cycle colour change and hSync edge
    vs = 1'b1; pixel = 1'b0; fg = 4'h5; bg = 4'h2; hs = 1'b1;
    tick(); tick(); tick(); tick();
    chk("p4_idle", {4'h0, col4}, 8'h02);
    pixel = 1'b1; hs = 1'b0;
    tick();
    chk("p4_n_col1", {4'h0, col1}, 8'h05);
    chk("p4_n_hs1",  {7'h0, hs1},  8'h0);
    chk("p4_n_col4", {4'h0, col4}, 8'h02);
    chk("p4_n_hs4",  {7'h0, hs4},  8'h1);
    pixel = 1'b0; hs = 1'b1;
    tick();
    chk("p4_n1_col4", {4'h0, col4}, 8'h02);
    tick();
    chk("p4_n2_col4", {4'h0, col4}, 8'h02);
    chk("p4_n2_hs4",  {7'h0, hs4},  8'h1);
    tick();
    chk("p4_n3_col4", {4'h0, col4}, 8'h05);
    chk("p4_n3_hs4",  {7'h0, hs4},  8'h0);
    tick();
    chk("p4_n4_col4", {4'h0, col4}, 8'h02);
    chk("p4_n4_hs4",  {7'h0, hs4},  8'h1);

    // Mid-line reset flushes all stages and restarts the blink counter
    pixel = 1'b1; hs = 1'b0; blink = 1'b1;
    tick(); tick(); tick(); tick();
    chk("pre_rst_col4", {4'h0, col4}, 8'h05);
    chk("pre_rst_col1", {4'h0, col1}, 8'h02);
    reset = 1'b1;
    tick();
    chk("mid_rst_col4", {4'h0, col4}, 8'h00);
    chk("mid_rst_hs4",  {7'h0, hs4},  8'h1);
    chk("mid_rst_col1", {4'h0, col1}, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("rel_col1", {4'h0, col1}, 8'h05);
    chk("rel0_col4", {4'h0, col4}, 8'h00);
    tick();
    chk("rel1_col4", {4'h0, col4}, 8'h00);
    tick();
    chk("rel2_col4", {4'h0, col4}, 8'h00);
    chk("rel2_hs4",  {7'h0, hs4},  8'h1);
    tick();
    chk("rel3_col4", {4'h0, col4}, 8'h05);
    chk("rel3_hs4",  {7'h0, hs4},  8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
